// File: rtl/decode_pkg.sv
// ============================================================================
// Module      : decode_pkg
// Description : Shared widths, control-bundle bit map and encodings for the
//               decode stage, its controller and the immediate generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

    localparam int E_CON_W = 9;
    localparam int M_CON_W = 7;
    localparam int W_CON_W = 6;

    // e_con: [3:0] alu op, [4] alu src imm, [5] rs2 unused, [6] branch, [7] jump, [8] pc src
    localparam int MEM_READ_BIT   = W_CON_W - 1;
    localparam int RS2_UNUSED_BIT = 5;
    localparam int RD_LSB         = 0;
    localparam int ALU_SRC_BIT    = 4;
    localparam int BRANCH_BIT     = 6;
    localparam int JUMP_BIT       = 7;
    localparam int PC_SRC_BIT     = 8;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_from_f3 = ALU_SLL;
            3'b010:  alu_from_f3 = ALU_SLT;
            3'b011:  alu_from_f3 = ALU_SLTU;
            3'b100:  alu_from_f3 = ALU_XOR;
            3'b101:  alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_from_f3 = ALU_OR;
            default: alu_from_f3 = ALU_AND;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/controller.sv
// ============================================================================
// Module      : controller
// Description : RV32I main decoder producing execute/memory/writeback bundles
//               and the immediate type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controller
    import decode_pkg::*;
(
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               funct7_b5,
    input  logic [4:0]         rd,
    output logic [E_CON_W-1:0] e_con,
    output logic [M_CON_W-1:0] m_con,
    output logic [W_CON_W-1:0] w_con,
    output imm_type_e          imm_sel
);

    // Stores and branches carry immediate bits in the rd field, so rd stays 0.
    always_comb begin
        e_con   = '0;
        m_con   = '0;
        w_con   = '0;
        imm_sel = IMM_I;
        case (opcode)
            OP_LUI: begin
                e_con[3:0]            = ALU_PASSB;
                e_con[ALU_SRC_BIT]    = 1'b1;
                e_con[RS2_UNUSED_BIT] = 1'b1;
                imm_sel               = IMM_U;
                w_con[RD_LSB +: 5]    = rd;
            end
            OP_AUIPC: begin
                e_con[ALU_SRC_BIT]    = 1'b1;
                e_con[RS2_UNUSED_BIT] = 1'b1;
                e_con[PC_SRC_BIT]     = 1'b1;
                imm_sel               = IMM_U;
                w_con[RD_LSB +: 5]    = rd;
            end
            OP_JAL: begin
                e_con[RS2_UNUSED_BIT] = 1'b1;
                e_con[JUMP_BIT]       = 1'b1;
                e_con[PC_SRC_BIT]     = 1'b1;
                imm_sel               = IMM_J;
                w_con[RD_LSB +: 5]    = rd;
            end
            OP_JALR: begin
                e_con[ALU_SRC_BIT]    = 1'b1;
                e_con[RS2_UNUSED_BIT] = 1'b1;
                e_con[JUMP_BIT]       = 1'b1;
                w_con[RD_LSB +: 5]    = rd;
            end
            OP_BRANCH: begin
                e_con[3:0]        = ALU_SUB;
                e_con[BRANCH_BIT] = 1'b1;
                m_con[4:2]        = funct3;
                imm_sel           = IMM_B;
            end
            OP_LOAD: begin
                e_con[ALU_SRC_BIT]    = 1'b1;
                e_con[RS2_UNUSED_BIT] = 1'b1;
                m_con[0]              = 1'b1;
                m_con[4:2]            = funct3;
                w_con[MEM_READ_BIT]   = 1'b1;
                w_con[RD_LSB +: 5]    = rd;
            end
            OP_STORE: begin
                e_con[ALU_SRC_BIT]    = 1'b1;
                e_con[RS2_UNUSED_BIT] = 1'b1;
                m_con[1]              = 1'b1;
                m_con[4:2]            = funct3;
                imm_sel               = IMM_S;
            end
            OP_IMM: begin
                e_con[3:0]            = alu_from_f3(funct3, (funct3 == 3'b101) & funct7_b5);
                e_con[ALU_SRC_BIT]    = 1'b1;
                e_con[RS2_UNUSED_BIT] = 1'b1;
                w_con[RD_LSB +: 5]    = rd;
            end
            OP_REG: begin
                e_con[3:0]         = alu_from_f3(funct3, funct7_b5);
                w_con[RD_LSB +: 5] = rd;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/decode_stage_hs_load_use_ctr.sv
// ============================================================================
// Module      : load_use_ctr
// Description : Load-use hazard compare against the output slot plus the
//               bubble counter that stretches the stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_ctr
    import decode_pkg::*;
#(
    parameter int W_CON_W      = decode_pkg::W_CON_W,
    parameter int LOAD_BUBBLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               adv,
    input  logic               out_valid,
    input  logic [W_CON_W-1:0] w_con,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic               rs2_unused,
    output logic               stall
);

    localparam logic [1:0] C_BUB_LOAD = 2'(LOAD_BUBBLES - 1);

    logic       w_hazard;
    logic [4:0] w_ld_rd;
    logic [1:0] r_bub_cnt;

    assign w_ld_rd  = w_con[4:0];
    assign w_hazard = out_valid & w_con[W_CON_W-1] & (w_ld_rd != 5'd0) &
                      ((w_ld_rd == rs1) | (~rs2_unused & (w_ld_rd == rs2)));
    assign stall    = w_hazard | (r_bub_cnt != 2'd0);

    // Counter only moves when the output slot advances, so backpressure freezes it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_bub_cnt <= 2'd0;
        end else if (adv && w_hazard) begin
            r_bub_cnt <= C_BUB_LOAD;
        end else if (adv && (r_bub_cnt != 2'd0)) begin
            r_bub_cnt <= r_bub_cnt - 2'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/imm_gen.sv
// ============================================================================
// Module      : imm_gen
// Description : Sign-extended immediate extraction for I/S/B/U/J formats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     inst,
    input  imm_type_e       imm_sel,
    output logic [XLEN-1:0] imm
);

    logic [31:0] w_imm32;

    always_comb begin
        w_imm32 = '0;
        case (imm_sel)
            IMM_I:   w_imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   w_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   w_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   w_imm32 = {inst[31:12], 12'h000};
            IMM_J:   w_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_sext
            assign imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_narrow
            assign imm = w_imm32[XLEN-1:0];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/decode_stage_hs.sv
// ============================================================================
// Module      : decode_stage_hs
// Description : Valid/ready decode stage with load-use bubble insertion and
//               flush. Define DECODE_WB_BYPASS_EN to forward the writeback
//               port into the captured operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage_hs
    import decode_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int E_CON_W      = decode_pkg::E_CON_W,
    parameter int M_CON_W      = decode_pkg::M_CON_W,
    parameter int W_CON_W      = decode_pkg::W_CON_W,
    parameter int LOAD_BUBBLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        inst,
    input  logic [XLEN-1:0]    pc,
    input  logic               flush,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    input  logic [XLEN-1:0]    rs1_out,
    input  logic [XLEN-1:0]    rs2_out,
    input  logic               wb_en,
    input  logic [4:0]         wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    opr1,
    output logic [XLEN-1:0]    opr2,
    output logic [XLEN-1:0]    imm,
    output logic [XLEN-1:0]    pc_out,
    output logic [4:0]         de_rs1,
    output logic [4:0]         de_rs2,
    output logic [E_CON_W-1:0] e_con,
    output logic [M_CON_W-1:0] m_con,
    output logic [W_CON_W-1:0] w_con,
    output logic               stall
);

    logic [decode_pkg::E_CON_W-1:0] w_ctl_e;
    logic [decode_pkg::M_CON_W-1:0] w_ctl_m;
    logic [decode_pkg::W_CON_W-1:0] w_ctl_w;
    imm_type_e                      w_imm_sel;
    logic [E_CON_W-1:0]             w_e_con;
    logic [M_CON_W-1:0]             w_m_con;
    logic [W_CON_W-1:0]             w_w_con;
    logic [XLEN-1:0]                w_imm;
    logic [XLEN-1:0]                w_opr1;
    logic [XLEN-1:0]                w_opr2;
    logic                           w_adv;

    logic                           r_out_valid;
    logic [XLEN-1:0]                r_opr1;
    logic [XLEN-1:0]                r_opr2;
    logic [XLEN-1:0]                r_imm;
    logic [XLEN-1:0]                r_pc;
    logic [4:0]                     r_de_rs1;
    logic [4:0]                     r_de_rs2;
    logic [E_CON_W-1:0]             r_e_con;
    logic [M_CON_W-1:0]             r_m_con;
    logic [W_CON_W-1:0]             r_w_con;

    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];

    controller u_controller (
        .opcode    (inst[6:0]),
        .funct3    (inst[14:12]),
        .funct7_b5 (inst[30]),
        .rd        (inst[11:7]),
        .e_con     (w_ctl_e),
        .m_con     (w_ctl_m),
        .w_con     (w_ctl_w),
        .imm_sel   (w_imm_sel)
    );

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst    (inst[31:7]),
        .imm_sel (w_imm_sel),
        .imm     (w_imm)
    );

    assign w_e_con = E_CON_W'(w_ctl_e);
    assign w_m_con = M_CON_W'(w_ctl_m);
    assign w_w_con = W_CON_W'(w_ctl_w);

`ifdef DECODE_WB_BYPASS_EN
    assign w_opr1 = (wb_en && (wb_rd == rs1) && (rs1 != 5'd0)) ? wb_data : rs1_out;
    assign w_opr2 = (wb_en && (wb_rd == rs2) && (rs2 != 5'd0)) ? wb_data : rs2_out;
`else
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_en, wb_rd, wb_data};
    assign w_opr1      = rs1_out;
    assign w_opr2      = rs2_out;
`endif

    assign w_adv    = ~r_out_valid | out_ready;
    assign in_ready = w_adv & ~stall & ~flush;

    load_use_ctr #(
        .W_CON_W      (W_CON_W),
        .LOAD_BUBBLES (LOAD_BUBBLES)
    ) u_load_use_ctr (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .adv        (w_adv),
        .out_valid  (r_out_valid),
        .w_con      (r_w_con),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs2_unused (w_e_con[RS2_UNUSED_BIT]),
        .stall      (stall)
    );

    // Datapath fields capture on every advance; only valid and controls mark a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_e_con     <= '0;
            r_m_con     <= '0;
            r_w_con     <= '0;
            r_opr1      <= '0;
            r_opr2      <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
            r_de_rs1    <= '0;
            r_de_rs2    <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_e_con     <= '0;
            r_m_con     <= '0;
            r_w_con     <= '0;
        end else if (w_adv) begin
            r_opr1   <= w_opr1;
            r_opr2   <= w_opr2;
            r_imm    <= w_imm;
            r_pc     <= pc;
            r_de_rs1 <= rs1;
            r_de_rs2 <= rs2;
            if (in_valid && in_ready) begin
                r_out_valid <= 1'b1;
                r_e_con     <= w_e_con;
                r_m_con     <= w_m_con;
                r_w_con     <= w_w_con;
            end else begin
                r_out_valid <= 1'b0;
                r_e_con     <= '0;
                r_m_con     <= '0;
                r_w_con     <= '0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign opr1      = r_opr1;
    assign opr2      = r_opr2;
    assign imm       = r_imm;
    assign pc_out    = r_pc;
    assign de_rs1    = r_de_rs1;
    assign de_rs2    = r_de_rs2;
    assign e_con     = r_e_con;
    assign m_con     = r_m_con;
    assign w_con     = r_w_con;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage_hs.sv
// ============================================================================
// Module      : tb_decode_stage_hs
// Description : Directed vector bench for decode_stage_hs (LOAD_BUBBLES=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage_hs;

    localparam int XLEN = 32;

`ifdef DECODE_WB_BYPASS_EN
    localparam bit C_BYP = 1'b1;
`else
    localparam bit C_BYP = 1'b0;
`endif

    localparam logic [31:0] C_ADDI_X1  = 32'h00100093;
    localparam logic [31:0] C_ADDI_X2  = 32'h00200113;
    localparam logic [31:0] C_LW_X5    = 32'h00002283;
    localparam logic [31:0] C_ADD_657  = 32'h00728333;
    localparam logic [31:0] C_LW_X0    = 32'h00002003;
    localparam logic [31:0] C_ADD_601  = 32'h00100333;
    localparam logic [31:0] C_SW_X5    = 32'h0050A023;
    localparam logic [31:0] C_ADDI_X4  = 32'h00018213;
    localparam logic [31:0] C_LUI_X1   = 32'h123450B7;
    localparam logic [31:0] C_SW_NEG4  = 32'hFE50AE23;
    localparam logic [31:0] C_RS2_DATA = 32'h00000707;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic            flush;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rs1_out;
    logic [XLEN-1:0] rs2_out;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] opr1;
    logic [XLEN-1:0] opr2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_out;
    logic [4:0]      de_rs1;
    logic [4:0]      de_rs2;
    logic [8:0]      e_con;
    logic [6:0]      m_con;
    logic [5:0]      w_con;
    logic            stall;

    int checks;
    int failures;

    decode_stage_hs #(
        .XLEN         (XLEN),
        .E_CON_W      (9),
        .M_CON_W      (7),
        .W_CON_W      (6),
        .LOAD_BUBBLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .pc        (pc),
        .flush     (flush),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1_out   (rs1_out),
        .rs2_out   (rs2_out),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opr1      (opr1),
        .opr2      (opr2),
        .imm       (imm),
        .pc_out    (pc_out),
        .de_rs1    (de_rs1),
        .de_rs2    (de_rs2),
        .e_con     (e_con),
        .m_con     (m_con),
        .w_con     (w_con),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        in_valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1_out;
        logic        out_ready;
        logic        flush;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        exp_in_ready;
        logic        exp_stall;
        logic        exp_ov;
        logic [5:0]  exp_wcon;
        logic        chk_dp;
        logic [31:0] exp_pc;
        logic [31:0] exp_opr1;
        logic        chk_imm;
        logic [31:0] exp_imm;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                                input logic [31:0] r1, input logic ordy, input logic fl,
                                input logic eir, input logic est, input logic eov,
                                input logic [5:0] ewc, input logic chk,
                                input logic [31:0] epc, input logic [31:0] eop1);
        vec_t v;
        v.in_valid = iv;      v.inst = ins;        v.pc = p;
        v.rs1_out = r1;       v.out_ready = ordy;  v.flush = fl;
        v.wb_en = 1'b0;       v.wb_rd = 5'd0;      v.wb_data = 32'h0;
        v.exp_in_ready = eir; v.exp_stall = est;   v.exp_ov = eov;
        v.exp_wcon = ewc;     v.chk_dp = chk;      v.exp_pc = epc;
        v.exp_opr1 = eop1;    v.chk_imm = 1'b0;    v.exp_imm = 32'h0;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        checks   = 0;
        failures = 0;

        // Garbage on the inputs while reset is held must not leak through.
        rst = 1'b1; in_valid = 1'b1; inst = C_ADDI_X1; pc = 32'h100;
        flush = 1'b0; rs1_out = 32'hAAAA_AAAA; rs2_out = C_RS2_DATA;
        wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", -1, 32'(out_valid), 32'h0);
        check("rst_ctrl", -1, {9'h0, e_con, m_con, w_con}, 32'h0);
        check("rst_opr1", -1, opr1, 32'h0);
        check("rst_opr2", -1, opr2, 32'h0);
        check("rst_imm", -1, imm, 32'h0);
        check("rst_pc_out", -1, pc_out, 32'h0);
        check("rst_de_rs", -1, {22'h0, de_rs1, de_rs2}, 32'h0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; inst = 32'h0;

        //                 iv inst        pc     rs1_out  ord fl  ir st ov wcon  dp epc    eopr1
        vq.push_back(mk(1, C_ADDI_X1, 32'h00, 32'h11, 1, 0, 1, 0, 1, 6'h01, 1, 32'h00, 32'h11));
        vq.push_back(mk(1, C_ADDI_X2, 32'h04, 32'h22, 1, 0, 1, 0, 1, 6'h02, 1, 32'h04, 32'h22));
        vq.push_back(mk(1, C_LW_X5,   32'h08, 32'h33, 1, 0, 1, 0, 1, 6'h25, 1, 32'h08, 32'h33));
        vq.push_back(mk(1, C_ADD_657, 32'h0C, 32'h44, 1, 0, 0, 1, 0, 6'h00, 0, 32'h00, 32'h00));
        vq.push_back(mk(1, C_ADD_657, 32'h0C, 32'h44, 1, 0, 0, 1, 0, 6'h00, 0, 32'h00, 32'h00));
        vq.push_back(mk(1, C_ADD_657, 32'h0C, 32'h55, 1, 0, 1, 0, 1, 6'h06, 1, 32'h0C, 32'h55));
        vq.push_back(mk(1, C_LW_X0,   32'h10, 32'h01, 1, 0, 1, 0, 1, 6'h20, 1, 32'h10, 32'h01));
        vq.push_back(mk(1, C_ADD_601, 32'h14, 32'h02, 1, 0, 1, 0, 1, 6'h06, 1, 32'h14, 32'h02));
        vq.push_back(mk(1, C_LW_X5,   32'h18, 32'h03, 1, 0, 1, 0, 1, 6'h25, 1, 32'h18, 32'h03));
        vq.push_back(mk(1, C_SW_X5,   32'h1C, 32'h04, 1, 0, 1, 0, 1, 6'h00, 1, 32'h1C, 32'h04));
        vq.push_back(mk(0, 32'h0,     32'h00, 32'h00, 1, 0, 1, 0, 0, 6'h00, 0, 32'h00, 32'h00));
        // backpressure: output holds for three cycles, then resumes
        vq.push_back(mk(1, C_ADDI_X1, 32'h20, 32'h66, 1, 0, 1, 0, 1, 6'h01, 1, 32'h20, 32'h66));
        vq.push_back(mk(1, C_ADDI_X2, 32'h24, 32'h77, 0, 0, 0, 0, 1, 6'h01, 1, 32'h20, 32'h66));
        vq.push_back(mk(1, C_ADDI_X2, 32'h24, 32'h77, 0, 0, 0, 0, 1, 6'h01, 1, 32'h20, 32'h66));
        vq.push_back(mk(1, C_ADDI_X2, 32'h24, 32'h77, 0, 0, 0, 0, 1, 6'h01, 1, 32'h20, 32'h66));
        vq.push_back(mk(1, C_ADDI_X2, 32'h24, 32'h77, 1, 0, 1, 0, 1, 6'h02, 1, 32'h24, 32'h77));
        // flush while one bubble is still pending
        vq.push_back(mk(1, C_LW_X5,   32'h28, 32'h08, 1, 0, 1, 0, 1, 6'h25, 1, 32'h28, 32'h08));
        vq.push_back(mk(1, C_ADD_657, 32'h2C, 32'h09, 1, 0, 0, 1, 0, 6'h00, 0, 32'h00, 32'h00));
        vq.push_back(mk(1, C_ADD_657, 32'h2C, 32'h09, 1, 1, 0, 1, 0, 6'h00, 0, 32'h00, 32'h00));
        vq.push_back(mk(1, C_ADD_657, 32'h2C, 32'h0A, 1, 0, 1, 0, 1, 6'h06, 1, 32'h2C, 32'h0A));
        // flush coinciding with a fresh hazard
        vq.push_back(mk(1, C_LW_X5,   32'h30, 32'h0B, 1, 0, 1, 0, 1, 6'h25, 1, 32'h30, 32'h0B));
        vq.push_back(mk(1, C_ADD_657, 32'h34, 32'h0C, 1, 1, 0, 1, 0, 6'h00, 0, 32'h00, 32'h00));
        vq.push_back(mk(1, C_ADD_657, 32'h34, 32'h0D, 1, 0, 1, 0, 1, 6'h06, 1, 32'h34, 32'h0D));
        // writeback port: forwarded only with the bypass build
        v = mk(1, C_ADDI_X4, 32'h38, 32'h00, 1, 0, 1, 0, 1, 6'h04, 1, 32'h38,
               C_BYP ? 32'hDEADBEEF : 32'h00);
        v.wb_en = 1'b1; v.wb_rd = 5'd3; v.wb_data = 32'hDEADBEEF;
        vq.push_back(v);
        v = mk(1, C_ADDI_X4, 32'h3C, 32'h99, 1, 0, 1, 0, 1, 6'h04, 1, 32'h3C, 32'h99);
        v.wb_en = 1'b1; v.wb_rd = 5'd0; v.wb_data = 32'hDEADBEEF;
        vq.push_back(v);
        // immediate formats
        v = mk(1, C_LUI_X1, 32'h40, 32'h00, 1, 0, 1, 0, 1, 6'h01, 1, 32'h40, 32'h00);
        v.chk_imm = 1'b1; v.exp_imm = 32'h12345000;
        vq.push_back(v);
        v = mk(1, C_SW_NEG4, 32'h44, 32'h5A, 1, 0, 1, 0, 1, 6'h00, 1, 32'h44, 32'h5A);
        v.chk_imm = 1'b1; v.exp_imm = 32'hFFFFFFFC;
        vq.push_back(v);

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            in_valid = v.in_valid; inst = v.inst; pc = v.pc; rs1_out = v.rs1_out;
            out_ready = v.out_ready; flush = v.flush;
            wb_en = v.wb_en; wb_rd = v.wb_rd; wb_data = v.wb_data;
            #1;
            check("in_ready", i, 32'(in_ready), 32'(v.exp_in_ready));
            check("stall", i, 32'(stall), 32'(v.exp_stall));
            check("rs1_rs2", i, {22'h0, rs1, rs2}, {22'h0, v.inst[19:15], v.inst[24:20]});
            @(posedge clk);
            #1;
            check("out_valid", i, 32'(out_valid), 32'(v.exp_ov));
            check("w_con", i, 32'(w_con), 32'(v.exp_wcon));
            if (!v.exp_ov) begin
                check("bubble_ctrl", i, {16'h0, e_con, m_con}, 32'h0);
            end
            if (v.chk_dp) begin
                check("pc_out", i, pc_out, v.exp_pc);
                check("opr1", i, opr1, v.exp_opr1);
                check("opr2", i, opr2, C_RS2_DATA);
                check("de_rs1", i, 32'(de_rs1), 32'(v.exp_ov ? v.inst[19:15] : 5'd0));
            end
            if (v.chk_imm) begin
                check("imm", i, imm, v.exp_imm);
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
